// File: rtl/cdc_fifo_sync_pkg.sv
// Shared defaults for the single-clock FIFO.
package cdc_fifo_sync_pkg;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned DefaultAddrSize  = 4;

endpackage

// File: rtl/cdc_fifo_sync_mem.sv
// Simple dual-port storage: synchronous write port, asynchronous read port, no reset.
module cdc_fifo_sync_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_SIZE  = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_SIZE-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_SIZE-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_SIZE;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the write word on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cdc_fifo_sync.sv
// Single-clock FWFT FIFO with registered full / almost-full / empty flags.
module cdc_fifo_sync
    import cdc_fifo_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned ADDR_SIZE  = DefaultAddrSize
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_inc,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_almost_full,
    output logic                  w_full,
    input  logic                  r_inc,
    output logic                  r_empty,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] AfullLevel = (ADDR_SIZE + 1)'(DEPTH - 1);

    logic [ADDR_SIZE:0] wptr_q, wptr_d;
    logic [ADDR_SIZE:0] rptr_q, rptr_d;
    logic [ADDR_SIZE:0] occ_d;
    logic               full_q, full_d;
    logic               afull_q, afull_d;
    logic               empty_q, empty_d;
    logic               w_accept, r_accept;

    // Gate requests with the registered flags, then derive next pointers and flags.
    always_comb begin
        w_accept = w_inc & ~full_q;
        r_accept = r_inc & ~empty_q;
        wptr_d   = wptr_q + (ADDR_SIZE + 1)'(w_accept);
        rptr_d   = rptr_q + (ADDR_SIZE + 1)'(r_accept);
        // Pointer difference is occupancy; the wrap bit makes DEPTH distinguishable from 0.
        occ_d    = wptr_d - rptr_d;
        full_d   = (wptr_d == {~rptr_d[ADDR_SIZE], rptr_d[ADDR_SIZE-1:0]});
        empty_d  = (wptr_d == rptr_d);
        afull_d  = (occ_d >= AfullLevel);
    end

    // Pointer and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            empty_q <= empty_d;
        end
    end

    assign w_full        = full_q;
    assign w_almost_full = afull_q;
    assign r_empty       = empty_q;

    cdc_fifo_sync_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_SIZE  (ADDR_SIZE)
    ) u_mem (
        .clk   (clk),
        .we    (w_accept),
        .waddr (wptr_q[ADDR_SIZE-1:0]),
        .wdata (w_data),
        .raddr (rptr_q[ADDR_SIZE-1:0]),
        .rdata (r_data)
    );

endmodule

// File: tb/tb_cdc_fifo_sync.sv
// Self-checking bench for cdc_fifo_sync: directed vector table, corner sequences, random traffic.
module tb_cdc_fifo_sync;

    localparam int unsigned DW    = 8;
    localparam int unsigned AS    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          w_inc;
    logic [DW-1:0] w_data;
    logic          w_almost_full;
    logic          w_full;
    logic          r_inc;
    logic          r_empty;
    logic [DW-1:0] r_data;

    int n_checks;
    int n_fail;

    // Reference model: plain queue of stored words.
    logic [DW-1:0] model_q [$];

    typedef struct {
        logic          w;
        logic [DW-1:0] d;
        logic          r;
        logic          e_empty;
        logic          e_full;
        logic          e_afull;
        logic          chk_data;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vecs [$];

    cdc_fifo_sync #(
        .DATA_WIDTH (DW),
        .ADDR_SIZE  (AS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .w_inc         (w_inc),
        .w_data        (w_data),
        .w_almost_full (w_almost_full),
        .w_full        (w_full),
        .r_inc         (r_inc),
        .r_empty       (r_empty),
        .r_data        (r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare DUT flags and head word against the queue model.
    task automatic check_model(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".empty"}, 32'(r_empty), 32'(sz == 0));
        check({tag, ".full"}, 32'(w_full), 32'(sz == DEPTH));
        check({tag, ".afull"}, 32'(w_almost_full), 32'(sz >= DEPTH - 1));
        if (sz > 0) check({tag, ".data"}, 32'(r_data), 32'(model_q[0]));
    endtask

    // Apply one cycle of requests, update the model, sample #1 after the edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        logic w_ok, r_ok;
        w_inc  = w;
        w_data = d;
        r_inc  = r;
        w_ok   = w && (model_q.size() != DEPTH);
        r_ok   = r && (model_q.size() != 0);
        @(posedge clk);
        #1;
        if (r_ok) void'(model_q.pop_front());
        if (w_ok) model_q.push_back(d);
        w_inc = 1'b0;
        r_inc = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        w_inc = 1'b0;
        r_inc = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_q.delete();
        check("reset.empty", 32'(r_empty), 32'd1);
        check("reset.full", 32'(w_full), 32'd0);
        check("reset.afull", 32'(w_almost_full), 32'd0);
    endtask

    function automatic vec_t mk(input logic w, input logic [DW-1:0] d, input logic r,
                                input logic ee, input logic ef, input logic ea,
                                input logic cd, input logic [DW-1:0] ed);
        vec_t v;
        v.w = w; v.d = d; v.r = r;
        v.e_empty = ee; v.e_full = ef; v.e_afull = ea;
        v.chk_data = cd; v.e_data = ed;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        w_inc    = 1'b0;
        w_data   = '0;
        r_inc    = 1'b0;

        // Directed table: fill, overflow, drain, underflow, refill.
        for (int i = 1; i <= 15; i++)
            vecs.push_back(mk(1'b1, 8'(41 + i), 1'b0, 1'b0, 1'b0, (i == 15), 1'b1, 8'd42));
        vecs.push_back(mk(1'b1, 8'd56, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd42));
        vecs.push_back(mk(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd42));
        for (int k = 1; k <= 16; k++)
            vecs.push_back(mk(1'b0, 8'h00, 1'b1, (k == 16), 1'b0, (k == 1), (k < 16),
                              (k <= 14) ? 8'(42 + k) : 8'd56));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));

        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 8'h00, 1'b0);
            check("idle.empty", 32'(r_empty), 32'd1);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].w, vecs[i].d, vecs[i].r);
            check($sformatf("vec%0d.empty", i), 32'(r_empty), 32'(vecs[i].e_empty));
            check($sformatf("vec%0d.full", i), 32'(w_full), 32'(vecs[i].e_full));
            check($sformatf("vec%0d.afull", i), 32'(w_almost_full), 32'(vecs[i].e_afull));
            if (vecs[i].chk_data)
                check($sformatf("vec%0d.data", i), 32'(r_data), 32'(vecs[i].e_data));
        end

        // Write while full with simultaneous read: write dropped, read proceeds.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        check_model("fill16");
        step(1'b1, 8'hEE, 1'b1);
        check_model("full_rw");
        check("full_rw.full", 32'(w_full), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check_model("full_rw_drain");
        end

        // Simultaneous read/write at half-full across pointer wrap.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 8'($urandom), 1'b1);
            check_model("half_rw");
            check("half_rw.occ", 32'(model_q.size()), 32'd8);
        end

        // Mid-operation reset with 5 words stored.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        check_model("pre_rst");
        do_reset();
        step(1'b1, 8'hA5, 1'b0);
        check("post_rst.data", 32'(r_data), 32'h0000_00A5);
        check("post_rst.empty", 32'(r_empty), 32'd0);

        // Random traffic against the queue model, biased to visit full and empty.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic w, r;
            if ((i / 100) % 2 == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            step(w, 8'($urandom), r);
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
